// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and dmem_responder.
// The core side uses the master modport, the responder the slave modport.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder in front of a word-addressed RAM.
// Defining DMEM_MMIO_EN adds the tohost register at MMIO_ADDR.
//
// state  | meaning
// S_IDLE | req_ready high, waiting for a request
// S_WAIT | wait-state down-counter running
// S_RESP | response held until rsp_ready
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 1,
   parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
`ifdef DMEM_MMIO_EN
   ,
   output logic [31:0]     tohost
`endif
);
   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] tohost_q, tohost_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic        op_we;
   logic [2:0]  op_size;
   logic [31:0] op_addr, op_wdata;
   logic        in_range, is_mmio, legal, mmio_ok, acc_err, do_access, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] wr_lanes, rd_word, ld_data;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      // With LATENCY==0 the access happens on the accept edge, so decode straight from the bus.
      op_we    = (state_q == S_IDLE) ? bus.req_we    : we_q;
      op_size  = (state_q == S_IDLE) ? bus.req_size  : size_q;
      op_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
      op_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;

      in_range = {2'b00, op_addr[31:2]} < DEPTH_WORDS;
      is_mmio  = (op_addr == MMIO_ADDR);
      legal    = 1'b0;
      mem_be   = 4'b0000;
      wr_lanes = op_wdata;
      case (op_size)
         3'b000: begin
            legal    = 1'b1;
            mem_be   = 4'b0001 << op_addr[1:0];
            wr_lanes = {4{op_wdata[7:0]}};
         end
         3'b001: begin
            legal    = !op_addr[0];
            mem_be   = op_addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{op_wdata[15:0]}};
         end
         3'b010: begin
            legal  = (op_addr[1:0] == 2'b00);
            mem_be = 4'b1111;
         end
         3'b100:  legal = !op_we;
         3'b101:  legal = !op_we && !op_addr[0];
         default: legal = 1'b0;
      endcase
`ifdef DMEM_MMIO_EN
      mmio_ok = (op_size == 3'b010);
`else
      mmio_ok = 1'b0;
`endif
      acc_err = is_mmio ? !mmio_ok : (!legal || !in_range);

      rd_word = mem[op_addr[AW+1:2]];
      rd_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
      rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (op_size)
         3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  ld_data = {24'h0, rd_byte};
         3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
         3'b101:  ld_data = {16'h0, rd_half};
         default: ld_data = rd_word;
      endcase
`ifdef DMEM_MMIO_EN
      if (is_mmio) ld_data = tohost_q;
`endif

      do_access = ((state_q == S_IDLE) && bus.req_valid && req_ready_q && (LATENCY == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));
      mem_we    = do_access && op_we && !acc_err && !is_mmio;

      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      tohost_d    = tohost_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               we_d        = bus.req_we;
               size_d      = bus.req_size;
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               req_ready_d = 1'b0;
               if (LATENCY == 0) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = LAT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_access) begin
         rsp_err_d   = acc_err;
         rsp_rdata_d = (acc_err || op_we) ? 32'h0 : ld_data;
         if (is_mmio && op_we && !acc_err) tohost_d = op_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         size_q      <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         tohost_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         tohost_q    <= tohost_d;
      end
   end

   // RAM is deliberately outside the reset domain; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[op_addr[AW+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
`ifdef DMEM_MMIO_EN
   assign tohost        = tohost_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, randomized traffic,
// plus a LATENCY=1 instance for reset state and first-response timing.
module tb_dmem_responder;
   localparam int          DEPTH = 256;
   localparam int          LAT   = 3;
   localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   exp_t        sb_q[$];
   logic [7:0]  mem_ref [0:4*DEPTH-1];
   logic [31:0] tohost_ref = 32'h0;
   int          bp_hold = 0;
   bit          in_rsp = 1'b0;
   bit          chk_rdy = 1'b0;
   logic [31:0] last_rdata;
   logic        last_err;

   dmem_responder_if ifc ();
   dmem_responder_if ifc1 ();
`ifdef DMEM_MMIO_EN
   logic [31:0] tohost, tohost1;
`endif

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MMIO_ADDR(MMIO)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
`ifdef DMEM_MMIO_EN
      , .tohost(tohost)
`endif
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .MMIO_ADDR(MMIO)) u_lat1 (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc1)
`ifdef DMEM_MMIO_EN
      , .tohost(tohost1)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
   endtask

   // Reference: access rules written directly over a byte array.
   task automatic ref_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
      int nb;
      logic [31:0] v;
      err = 1'b0; rdata = 32'h0; nb = 0;
`ifdef DMEM_MMIO_EN
      if (addr == MMIO) begin
         if (size != 3'b010) err = 1'b1;
         else if (we) tohost_ref = wdata;
         else rdata = tohost_ref;
         return;
      end
`endif
      case (size)
         3'b000, 3'b100: nb = 1;
         3'b001, 3'b101: nb = 2;
         3'b010:         nb = 4;
         default:        err = 1'b1;
      endcase
      if (nb != 0 && (addr % nb) != 0) err = 1'b1;
      if (addr >= 4 * DEPTH) err = 1'b1;
      if (we && (size == 3'b100 || size == 3'b101)) err = 1'b1;
      if (err) return;
      if (we) begin
         for (int i = 0; i < nb; i++) mem_ref[addr + i] = wdata[8*i +: 8];
         return;
      end
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_ref[addr + i]) << (8 * i));
      if (size == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (size == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      rdata = v;
   endtask

   task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit push);
      exp_t e;
      int guard;
      @(negedge clk);
      ifc.req_we = we; ifc.req_size = size; ifc.req_addr = addr; ifc.req_wdata = wdata;
      ifc.req_valid = 1'b1;
      guard = 0;
      while (!ifc.req_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!ifc.req_ready) begin
         fail_now("req_accept");
         ifc.req_valid = 1'b0;
         return;
      end
      if (push) begin
         ref_access(we, size, addr, wdata, e.err, e.rdata);
         e.acc_cyc = cyc;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      ifc.req_valid = 1'b0;
      ifc.req_we    = 1'($urandom);
      ifc.req_size  = 3'($urandom);
      ifc.req_addr  = $urandom;
      ifc.req_wdata = $urandom;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (sb_q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0) begin
         fail_now(name);
         sb_q.delete();
      end
   endtask

   task automatic lat1_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output int n, output logic err,
                           output logic [31:0] rdata);
      @(negedge clk);
      ifc1.req_we = we; ifc1.req_size = size; ifc1.req_addr = addr; ifc1.req_wdata = wdata;
      ifc1.req_valid = 1'b1;
      @(posedge clk);
      #1 ifc1.req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifc1.rsp_valid && n < 20);
      err   = ifc1.rsp_err;
      rdata = ifc1.rsp_rdata;
      ifc1.rsp_ready = 1'b1;
      @(posedge clk);
      #1 ifc1.rsp_ready = 1'b0;
   endtask

   // Monitor: owns rsp_ready and compares each completed response with the scoreboard head.
   initial begin
      exp_t e;
      ifc.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_rdy) begin
            chk("req_ready_after_rsp", 32'(ifc.req_ready), 32'd1);
            chk_rdy = 1'b0;
         end
         if (!reset) begin
            in_rsp = 1'b0;
            ifc.rsp_ready = 1'b0;
         end else if (ifc.rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_rsp", 32'(ifc.rsp_valid), 32'd0);
               ifc.rsp_ready = 1'b1;
            end else begin
               if (!in_rsp) begin
                  chk("rsp_latency", 32'(cyc - sb_q[0].acc_cyc), 32'(LAT + 1));
                  in_rsp = 1'b1;
               end else begin
                  chk("rsp_rdata_stable", ifc.rsp_rdata, last_rdata);
                  chk("rsp_err_stable", 32'(ifc.rsp_err), 32'(last_err));
               end
               last_rdata = ifc.rsp_rdata;
               last_err   = ifc.rsp_err;
               chk("req_ready_in_resp", 32'(ifc.req_ready), 32'd0);
               if (bp_hold > 0) begin
                  ifc.rsp_ready = 1'b0;
                  bp_hold--;
               end else begin
                  ifc.rsp_ready = ($urandom_range(0, 3) != 0);
               end
               if (ifc.rsp_ready) begin
                  e = sb_q.pop_front();
                  chk("rsp_err", 32'(ifc.rsp_err), 32'(e.err));
                  chk("rsp_rdata", ifc.rsp_rdata, e.rdata);
                  in_rsp  = 1'b0;
                  chk_rdy = 1'b1;
               end
            end
         end else begin
            in_rsp = 1'b0;
            ifc.rsp_ready = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic e1;
      logic [31:0] d1;
      logic [2:0] sizes [5];
      logic [31:0] a;
      logic [2:0] s;
      int r;
      sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b100; sizes[4] = 3'b101;

      ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_size = 3'b000;
      ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
      ifc1.req_valid = 1'b0; ifc1.req_we = 1'b0; ifc1.req_size = 3'b000;
      ifc1.req_addr = 32'h0; ifc1.req_wdata = 32'h0; ifc1.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
      chk("rst1_req_ready", 32'(ifc1.req_ready), 32'd1);
      chk("rst1_rsp_valid", 32'(ifc1.rsp_valid), 32'd0);
      chk("rst1_rsp_rdata", ifc1.rsp_rdata, 32'h0);
`ifdef DMEM_MMIO_EN
      chk("rst_tohost", tohost, 32'h0);
`endif

      lat1_txn(1'b1, 3'b010, 32'h0, 32'h1234_5678, n, e1, d1);
      chk("lat1_sw_latency", 32'(n), 32'd2);
      chk("lat1_sw_err", 32'(e1), 32'd0);
      chk("lat1_sw_rdata", d1, 32'h0);
      lat1_txn(1'b0, 3'b010, 32'h0, 32'h0, n, e1, d1);
      chk("lat1_lw_latency", 32'(n), 32'd2);
      chk("lat1_lw_rdata", d1, 32'h1234_5678);

      for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'b010, 32'(4 * w), $urandom, 1'b1);
      drain("drain_fill");

      issue(1'b1, 3'b010, 32'h0, 32'h1234_5678, 1'b1);
      issue(1'b1, 3'b010, 32'h4, 32'h80FF_7F01, 1'b1);
      issue(1'b0, 3'b000, 32'h7, 32'h0, 1'b1);
      issue(1'b0, 3'b100, 32'h7, 32'h0, 1'b1);
      issue(1'b0, 3'b001, 32'h4, 32'h0, 1'b1);
      issue(1'b0, 3'b101, 32'h6, 32'h0, 1'b1);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1);
      issue(1'b1, 3'b000, 32'h5, 32'h0000_00AB, 1'b1);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1);
      issue(1'b0, 3'b010, 32'h2, 32'h0, 1'b1);
      issue(1'b0, 3'b001, 32'h1, 32'h0, 1'b1);
      issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b1);
      issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 3'b010, 32'h2, 32'hFFFF_FFFF, 1'b1);
      issue(1'b1, 3'b100, 32'h0, 32'h0000_00EE, 1'b1);
      issue(1'b1, 3'b111, 32'h0, 32'hFFFF_FFFF, 1'b1);
      issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 3'b001, 32'hA, 32'h0000_9001, 1'b1);
      issue(1'b0, 3'b001, 32'hA, 32'h0, 1'b1);
      issue(1'b0, 3'b101, 32'hA, 32'h0, 1'b1);
      issue(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b1);
      drain("drain_directed");

      issue(1'b1, 3'b010, MMIO, 32'h0000_0001, 1'b1);
      issue(1'b0, 3'b010, MMIO, 32'h0, 1'b1);
      issue(1'b0, 3'b001, MMIO, 32'h0, 1'b1);
      drain("drain_mmio");
`ifdef DMEM_MMIO_EN
      chk("tohost_after_sw", tohost, 32'h0000_0001);
`endif

      bp_hold = 5;
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1);
      drain("drain_backpressure");

      issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midwait_rst_req_ready", 32'(ifc.req_ready), 32'd1);
      chk("midwait_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b1);
      drain("drain_midwait");

      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 15);
         if (r <= 12)      a = 32'($urandom_range(0, 4 * DEPTH - 1));
         else if (r == 13) a = 32'(4 * DEPTH + $urandom_range(0, 63));
         else if (r == 14) a = MMIO;
         else              a = $urandom;
         if ($urandom_range(0, 7) != 0) s = sizes[$urandom_range(0, 4)];
         else                           s = 3'($urandom);
         if (s == 3'b010 && $urandom_range(0, 1) == 1) a = {a[31:2], 2'b00};
         if ((s == 3'b001 || s == 3'b101) && $urandom_range(0, 1) == 1) a = {a[31:1], 1'b0};
         issue(1'($urandom), s, a, $urandom, 1'b1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain("drain_random");
`ifdef DMEM_MMIO_EN
      chk("tohost_final", tohost, tohost_ref);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the core's load/store port: accepts one load/store request at a time, applies LATENCY wait states, performs the access on an internal word-addressed RAM, returns a response.
- Serves sw/sh/sb and lw/lh/lb/lhu/lbu issued by core.
- Single outstanding transaction; valid/ready handshakes on both request and response channels.

Parameters:
DEPTH_WORDS, 256, number of 32-bit RAM words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
LATENCY, 1, wait-state cycles between request acceptance and response (0..15)
MMIO_ADDR, 32'hFFFF_FFF0, tohost register address (used only with optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
req_valid  input  1  request present
req_ready  output  1  responder can accept request
req_we  input  1  1 = store, 0 = load
req_size  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  access fault (misaligned, out of range, illegal size)
tohost  output  32  MMIO register (present only when DMEM_MMIO_EN defined)

Behaviour:
- Reset (reset==0, async): state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, tohost=0, wait counter=0. RAM contents not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/size/addr/wdata. LATENCY==0 -> RESP next cycle; else load counter with LATENCY-1 and -> WAIT.
- WAIT: req_ready=0. Counter decrements each cycle; at 0 -> RESP next cycle. Total accept-edge to first rsp_valid = LATENCY+1 cycles.
- Access performed on the edge entering RESP: store writes selected bytes; load captures rsp_rdata. rsp_rdata/rsp_err registered, stable throughout RESP.
- RESP: rsp_valid=1, req_ready=0. Hold until rsp_ready=1 -> IDLE next cycle. New request cannot be accepted in the same cycle the response completes (req_ready=1 only from the following cycle).
- Byte lanes: b/bu lane addr[1:0]; h/hu lane addr[1]; w all lanes. Store byte from req_wdata[7:0], half from [15:0].
- Load extension: b, h sign-extend; bu, hu zero-extend; w as-is.
- Error conditions (rsp_err=1, rsp_rdata=0, no RAM write): size h/hu with addr[0]=1; size w with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS; req_size in {011,110,111}; store with size bu/hu.
- Multiple error causes give the single rsp_err=1; no priority distinction.
- Reset asserted mid-WAIT: transaction dropped, no RAM write. Reset in RESP: response discarded, write already done stays.
- req_* inputs ignored outside IDLE.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined: tohost port exists. sw (size 010) to MMIO_ADDR writes req_wdata to tohost, RAM untouched, rsp_err=0. lw from MMIO_ADDR returns tohost. Any other size at MMIO_ADDR -> rsp_err=1.
- Not defined: tohost port absent; MMIO_ADDR is ordinary out-of-range address -> rsp_err=1.

Test Plan:
- Reset, LATENCY=1: reset low then high -> req_ready=1, rsp_valid=0, rsp_rdata=0; sw addr 0x0 data 0x1234_5678 -> rsp_valid exactly 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Load extension: after word store 0x80FF_7F01 at 0x4, lb 0x7 -> 0xFFFF_FF80; lbu 0x7 -> 0x0000_0080; lh 0x4 -> 0x0000_7F01; lhu 0x6 -> 0x0000_80FF; lw 0x4 -> 0x80FF_7F01.
- Byte store: sb 0xAB to 0x5 over 0x80FF_7F01 -> lw 0x4 returns 0x80FF_AB01.
- Errors: lw 0x2, lh 0x1, lw 0x400 (DEPTH_WORDS=256), size 011 -> each rsp_err=1, rsp_rdata=0; prior word at 0x0 unchanged.
- Backpressure/latency: LATENCY=3, rsp_ready held 0 for 5 cycles -> rsp_valid stable with constant rsp_rdata, req_ready=0 throughout; after rsp_ready=1, req_ready=1 one cycle later; reset pulse during WAIT of sw 0x8 data 0xDEAD_BEEF -> later lw 0x8 returns previous value.
- DMEM_MMIO_EN: sw 0xFFFF_FFF0 data 0x0000_0001 -> tohost=0x0000_0001, rsp_err=0; lw same address -> 0x0000_0001; without macro same sw -> rsp_err=1.
